// File: rtl/aes_pkg.sv
// Shared AES types, round-count constant and round-constant lookup for cipher and decipher paths.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  // Rcon for rounds 1..10; unused indices return zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
// No latency, no flow control; shared with the cipher datapath.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  // Entry 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle, rk 0 the cycle after start, rk 10 with done.
// No backpressure: start is taken only while idle and ignored while busy; round key 10 is held after done.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic         done,
  output logic [127:0] round_key_10
);

  state_e     state;
  logic [3:0] round;
  block_t     key_reg;
  block_t     next_key;
  word_t      w0, w1, w2, w3;
  word_t      rot, sub, temp;
  word_t      n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_reg;
  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .value (rot[8*i +: 8]),
      .subst (sub[8*i +: 8])
    );
  end

  assign temp     = sub ^ {rcon(round + 4'd1), 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      round        <= '0;
      key_reg      <= '0;
      rk_valid     <= 1'b0;
      done         <= 1'b0;
      round_key_10 <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_reg  <= cipher_key;
            round    <= '0;
            state    <= ST_EXPAND;
            rk_valid <= 1'b1;
          end
        end
        ST_EXPAND: begin
          key_reg  <= next_key;
          round    <= round + 4'd1;
          rk_valid <= 1'b1;
          // Final round: back to idle so a new start can be taken in the done cycle.
          if (round == 4'(NR - 1)) begin
            state        <= ST_IDLE;
            done         <= 1'b1;
            round_key_10 <= next_key;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_EXPAND);
  assign rk_index = round;
  assign rk_data  = key_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic [127:0] rk_data;
  logic         done;
  logic [127:0] round_key_10;

  aes_key_expand #(.NR(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cipher_key   (cipher_key),
    .busy         (busy),
    .rk_valid     (rk_valid),
    .rk_index     (rk_index),
    .rk_data      (rk_data),
    .done         (done),
    .round_key_10 (round_key_10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] ZERO_RK [0:10] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           idx0_cyc = 0;
  int           pulses = 0;
  int           done_cnt = 0;
  logic [127:0] exp_rk10 = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sched(input logic [127:0] tbl [0:10]);
    for (int i = 0; i <= 10; i++) sb_q.push_back('{4'(i), tbl[i]});
  endtask

  // Monitor: pops the next expected round key whenever the DUT presents one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_rk10 = '0;
      end else begin
        if (rk_valid) begin
          pulses++;
          if (done) done_cnt++;
          if (sb_q.size() == 0) begin
            check("unexpected_rk_valid", 128'(rk_index), 128'hff);
          end else begin
            e = sb_q.pop_front();
            check("rk_index", 128'(rk_index), 128'(e.idx));
            check("rk_data", rk_data, e.data);
            check("done_at_rk", 128'(done), 128'(e.idx == 4'd10));
            check("busy_at_rk", 128'(busy), 128'(e.idx != 4'd10));
            if (e.idx == 4'd0) idx0_cyc = cyc;
            if (e.idx == 4'd10) begin
              exp_rk10 = e.data;
              check("done_latency", 128'(cyc - idx0_cyc), 128'd10);
            end
          end
        end else begin
          check("idle_done", 128'(done), 128'd0);
          check("idle_busy", 128'(busy), 128'd0);
        end
        check("round_key_10", round_key_10, exp_rk10);
      end
    end
  end

  task automatic issue(input logic [127:0] key);
    cipher_key = key;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(sb_q.size()), 128'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_rk_index"}, 128'(rk_index), 128'd0);
    check({tag, "_rk_data"}, rk_data, 128'd0);
    check({tag, "_round_key_10"}, round_key_10, 128'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    cipher_key = '0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // FIPS-197 A.1 key schedule.
    push_sched(FIPS_RK);
    issue(FIPS_KEY);
    drain("fips_drain");

    // All-zero key: exactly 11 pulses.
    pulses = 0;
    push_sched(ZERO_RK);
    issue(ZERO_KEY);
    drain("zero_drain");
    check("zero_pulses", 128'(pulses), 128'd11);

    // Start pulses with another key while busy are ignored.
    done_cnt = 0;
    push_sched(FIPS_RK);
    issue(FIPS_KEY);
    repeat (2) @(negedge clk);
    cipher_key = ALT_KEY;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain("busy_drain");
    repeat (12) @(negedge clk);
    check("busy_done_count", 128'(done_cnt), 128'd1);

    // Back-to-back: start held, key B presented in A's done cycle.
    push_sched(FIPS_RK);
    push_sched(ZERO_RK);
    @(negedge clk);
    cipher_key = FIPS_KEY;
    start      = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    check("b2b_a_done_seen", 128'(done), 128'd1);
    cipher_key = ZERO_KEY;
    @(posedge clk);
    #1 start = 1'b0;
    drain("b2b_drain");

    // Asynchronous reset in the middle of an expansion.
    push_sched(FIPS_RK);
    issue(FIPS_KEY);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_outputs_zero("midreset");
    done_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midreset_no_done", 128'(done_cnt), 128'd0);
    push_sched(FIPS_RK);
    issue(FIPS_KEY);
    drain("post_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
